// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/Full_Subtractor.sv
// One-bit full subtractor: D = X - Y - Z, B is the borrow out.
module Full_Subtractor (
  output logic D,
  output logic B,
  input  logic X,
  input  logic Y,
  input  logic Z
);

  assign D = X ^ Y ^ Z;
  assign B = (~X & Y) | (~(X ^ Y) & Z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single Full_Subtractor.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             fs_d, fs_b;
  logic             last_bit;

  Full_Subtractor u_fs (fs_d, fs_b, a_sr[0], b_sr[0], borrow);

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          borrow <= fs_b;
          if (last_bit) begin
            diff       <= {fs_d, res_sr[WIDTH-1:1]};
            borrow_out <= fs_b;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor producing diff = a - b over WIDTH bits, LSB first, one bit per clock.
- Sits directly around the existing Full_Subtractor cell, which is instantiated once as its datapath.
- Feeds that cell one (X, Y, Z) triple per cycle and consumes its D/B outputs, latching B back as the next Z.
- Trades WIDTH cycles of latency for a single subtractor cell; a start/busy/done handshake frames each operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: diff/borrow_out are valid.
- diff  output  WIDTH  result a - b mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal borrow=0, bit counter=0, shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 at an edge.
  - On that edge: a_sr<=a, b_sr<=b, borrow<=0, cnt<=0.
- RUN:
  - Full_Subtractor inputs are X=a_sr[0], Y=b_sr[0], Z=borrow.
  - Each edge: a_sr and b_sr shift right one bit.
  - Each edge: D shifts into the MSB of res_sr (shift right), borrow<=B, cnt<=cnt+1.
- RUN -> DONE on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH processed bits.
  - On that edge: diff<=final res_sr value and borrow_out<=final B.
- DONE -> IDLE unconditionally on the next edge.
- Latency:
  - start sampled at edge t.
  - busy=1 during cycles t+1..t+WIDTH.
  - done=1 for exactly one cycle, after edge t+WIDTH.
  - Earliest next start is sampled at edge t+WIDTH+2.
- Outputs:
  - busy is asserted only in RUN; done only in DONE.
  - diff and borrow_out hold their last result until the next DONE, or until reset. They are not cleared at start.
- Start in RUN or DONE is ignored. No queueing and no error flag.
- Changes on a/b after capture have no effect on the operation in flight.
- Arithmetic:
  - diff == (a - b) mod 2^WIDTH.
  - borrow_out == (a < b), where a and b are unsigned.
  - Equivalent result: {borrow_out, diff} == {1'b0, a} - {1'b0, b} in WIDTH+1-bit two's complement.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1 occurs.
- rst asserted mid-operation:
  - Immediate return to IDLE with all reset values; the partial result is discarded.
  - done never pulses for an aborted operation.
- start held high continuously: a new operation begins at every IDLE cycle, i.e. back-to-back with one DONE and one IDLE cycle in between.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE, RUN, DONE), 2 bits.
  - localparam DEFAULT_WIDTH=8.
  - function cnt_w(width) returning $clog2(width).
- Sub-module: exactly one instance of the existing Full_Subtractor, connected positionally (D, B, X, Y, Z).
  - No other sub-modules.
  - Control FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, start one cycle:
  - busy high exactly 8 cycles.
  - done one cycle later: diff=8'h1E, borrow_out=0.
- a=8'h3C, b=8'h5A -> diff=8'hE2, borrow_out=1.
- a=8'h00, b=8'h01 (full borrow ripple) -> diff=8'hFF, borrow_out=1.
- a=b=8'hFF -> diff=8'h00, borrow_out=0.
- Start ignored while busy:
  - Start 5A/3C, then at busy cycle 3 pulse start with a=8'h01, b=8'h02.
  - Required: single done with diff=8'h1E. No second done, no busy extension.
- Reset mid-operation:
  - Start a=8'h80, b=8'h01; assert rst asynchronously (between edges) at busy cycle 4.
  - Required: busy/done/diff/borrow_out go to 0 without waiting for a clock edge.
  - After release, a new start with a=8'h10, b=8'h01 yields diff=8'h0F, borrow_out=0 after 8 busy cycles.
- Exhaustive sweep, WIDTH=4: all 256 (a,b) pairs back-to-back with start held high.
  - Every done gives diff == (a-b)&4'hF and borrow_out == (a<b).
  - Spacing between done pulses is exactly 6 cycles (start edge, 4 RUN cycles, DONE).
